// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
//   Shared types and default sizes for the valid/ready byte-stream producer.
//
//   prod_state_t : producer FSM state (IDLE / CAPTURE / DRAIN)
//   beat_t       : one stream beat at the default data width {data, last}
//   DEF_*        : default parameter values used by stream_producer
// -----------------------------------------------------------------------------
package stream_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_PKT_LEN    = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } prod_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with a registered head. dout always presents the oldest
//   entry while the FIFO is non-empty and only changes on a push into an empty
//   FIFO or on a pop, so a downstream valid/ready sink sees stable data.
//
//   Pointers are log2(DEPTH)+1 bits wide: the extra MSB tells full from empty
//   when the index bits match, and both pointers simply wrap.
//
//   Ports
//     clk    in   1      clock
//     rst    in   1      synchronous, active-high reset (empties the FIFO)
//     push   in   1      write din; accepted unless full with no pop this cycle
//     din    in   WIDTH  entry to write
//     pop    in   1      remove the head entry (ignored when empty)
//     dout   out  WIDTH  registered head entry (0 after reset)
//     full   out  1      DEPTH entries held
//     empty  out  1      no entries held
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_next;
  logic [AW:0]      rd_next;
  logic             do_push;
  logic             do_pop;
  logic             load_head;
  logic [WIDTH-1:0] head_d;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign wr_next = wr_ptr + (AW+1)'(do_push);
  assign rd_next = rd_ptr + (AW+1)'(do_pop);

  // Reload the head only when the head entry changes and something remains;
  // otherwise hold, so dout never picks up an unwritten slot.
  assign load_head = (do_push || do_pop) && (wr_next != rd_next);

  // The next head is either already in memory, or it is the entry being
  // written this cycle (push into empty, or pop of the only entry with push).
  always_comb begin
    // NOTE: assign a default before any conditional update in combinational
    // logic; a path that leaves the signal unassigned infers a latch.
    head_d = mem[rd_next[AW-1:0]];
    if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
      head_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      if (load_head) begin
        dout <= head_d;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are meaningful, and leaving the array out of reset lets it
  // map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/stream_producer.sv
// -----------------------------------------------------------------------------
// stream_producer
//   Transmit end of the valid/ready byte stream. A start pulse opens a packet;
//   PKT_LEN samples are then captured, one per sample_en strobe, buffered in a
//   small FIFO and sent with m_last on the final beat.
//
//   If the FIFO is full (and not being popped) when a sample arrives, that
//   sample is dropped and the sticky overflow flag is set; the beat counter
//   does not advance, so the packet still carries exactly PKT_LEN beats.
//
//   Parameters
//     DATA_W      sample / m_data width
//     PKT_LEN     beats per packet (>= 2)
//     FIFO_DEPTH  buffer entries (power of 2, >= 2)
//
//   Build option
//     STREAM_PRODUCER_PARITY_EN  adds m_parity = ^m_data, stored per entry
//
//   Ports
//     clk        in   1       clock
//     rst        in   1       synchronous, active-high reset
//     start      in   1       begin a packet (ignored while busy)
//     sample_en  in   1       capture strobe
//     sample     in   DATA_W  value captured when sample_en=1
//     m_valid    out  1       beat available (FIFO non-empty)
//     m_ready    in   1       consumer accepts the beat
//     m_data     out  DATA_W  beat payload (registered FIFO head)
//     m_last     out  1       final beat of packet
//     busy       out  1       packet in progress
//     overflow   out  1       sticky: a sample was dropped since last start
//     m_parity   out  1       even parity of m_data (parity build only)
// -----------------------------------------------------------------------------
module stream_producer
  import stream_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PKT_LEN    = DEF_PKT_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              overflow
`ifdef STREAM_PRODUCER_PARITY_EN
  ,
  output logic              m_parity
`endif
);

  localparam int CNT_W = $clog2(PKT_LEN);

`ifdef STREAM_PRODUCER_PARITY_EN
  localparam int ENTRY_W = DATA_W + 2;
`else
  localparam int ENTRY_W = DATA_W + 1;
`endif

  prod_state_t        state_q;
  prod_state_t        state_d;
  logic [CNT_W-1:0]   count_q;
  logic               start_ok;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               is_last;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] entry_out;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)                     state_d = CAPTURE;
      CAPTURE: if (push_ok && is_last)        state_d = DRAIN;
      DRAIN:   if (pop && m_last)             state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = 1'b0;
    start_ok = 1'b0;
    push_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_ok = start;
      end
      CAPTURE: begin
        busy     = 1'b1;
        push_req = sample_en;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Push / pop qualification
  // ---------------------------------------------------------------------------
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign is_last = (count_q == CNT_W'(PKT_LEN - 1));
  // Mirrors the FIFO's own acceptance rule so the counter and overflow flag
  // track exactly the pushes the FIFO takes.
  assign push_ok = push_req && (!fifo_full || pop);

  // ---------------------------------------------------------------------------
  // Beat counter and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      overflow <= 1'b0;
    end else if (start_ok) begin
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        // Explicit wrap keeps non-power-of-2 packet lengths correct.
        count_q <= is_last ? '0 : count_q + CNT_W'(1);
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beat buffer
  // ---------------------------------------------------------------------------
`ifdef STREAM_PRODUCER_PARITY_EN
  assign entry_in = {^sample, sample, is_last};
  assign m_parity = entry_out[DATA_W+1];
`else
  assign entry_in = {sample, is_last};
`endif

  assign m_data = entry_out[DATA_W:1];
  assign m_last = entry_out[0];

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .din   (entry_in),
    .pop   (pop),
    .dout  (entry_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_stream_producer.sv
// -----------------------------------------------------------------------------
// tb_stream_producer
//   Two producers share clock, reset and the sample source:
//     dut a : PKT_LEN=4, FIFO_DEPTH=4 (packet fits the buffer)
//     dut b : PKT_LEN=8, FIFO_DEPTH=4 (packet exceeds the buffer, can overflow)
//   A queue-based packet model follows each producer cycle by cycle; directed
//   scenarios add explicit expected beat lists on top of the model.
//   Build with +define+STREAM_PRODUCER_PARITY_EN to cover m_parity.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_producer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LEN_A = 4;
  localparam int LEN_B = 8;
`ifdef STREAM_PRODUCER_PARITY_EN
  localparam int VW = 13;
`else
  localparam int VW = 12;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic          sample_en = 1'b0;
  logic [DW-1:0] sample = '0;
  logic          ready_a = 1'b0, ready_b = 1'b0;

  logic          va, la, busy_a, ovf_a;
  logic          vb, lb, busy_b, ovf_b;
  logic [DW-1:0] da, db;
`ifdef STREAM_PRODUCER_PARITY_EN
  logic          pa, pb;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per producer a queue of {data,last}, a phase (0 idle, 1 capture,
  // 2 drain), the number of beats captured so far and the overflow flag.
  logic [DW:0] q0[$], q1[$];
  int          ph[2]    = '{0, 0};
  int          cnt[2]   = '{0, 0};
  bit          ovf_m[2] = '{0, 0};

  // Beats seen crossing the interface (valid & ready at the clock edge).
  logic [DW:0] obs_a[$], obs_b[$];

  always #5 clk = ~clk;

  stream_producer #(.DATA_W(DW), .PKT_LEN(LEN_A), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
    .sample_en (sample_en),
    .sample    (sample),
    .m_valid   (va),
    .m_ready   (ready_a),
    .m_data    (da),
    .m_last    (la),
    .busy      (busy_a),
    .overflow  (ovf_a)
`ifdef STREAM_PRODUCER_PARITY_EN
    ,
    .m_parity  (pa)
`endif
  );

  stream_producer #(.DATA_W(DW), .PKT_LEN(LEN_B), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .sample_en (sample_en),
    .sample    (sample),
    .m_valid   (vb),
    .m_ready   (ready_b),
    .m_data    (db),
    .m_last    (lb),
    .busy      (busy_b),
    .overflow  (ovf_b)
`ifdef STREAM_PRODUCER_PARITY_EN
    ,
    .m_parity  (pb)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int qsize(int d);
    return (d != 0) ? q1.size() : q0.size();
  endfunction

  function automatic logic [DW:0] qhead(int d);
    if (d != 0) return (q1.size() > 0) ? q1[0] : '0;
    return (q0.size() > 0) ? q0[0] : '0;
  endfunction

  function automatic void qpop(int d);
    if (d != 0) void'(q1.pop_front());
    else        void'(q0.pop_front());
  endfunction

  function automatic void qpush(int d, logic [DW:0] v);
    if (d != 0) q1.push_back(v);
    else        q0.push_back(v);
  endfunction

  function automatic void model_step(int d);
    logic        rdy, st, popped_last;
    logic [DW:0] b;
    int          ph0, len;
    rdy = (d != 0) ? ready_b : ready_a;
    st  = (d != 0) ? start_b : start_a;
    len = (d != 0) ? LEN_B : LEN_A;
    if (rst) begin
      if (d != 0) q1.delete();
      else        q0.delete();
      ph[d] = 0; cnt[d] = 0; ovf_m[d] = 1'b0;
      return;
    end
    ph0 = ph[d];
    popped_last = 1'b0;
    if (qsize(d) > 0 && rdy) begin
      b = qhead(d);
      popped_last = b[0];
      qpop(d);
    end
    // A sample fits if there is room once this cycle's transfer has left.
    if (ph0 == 1 && sample_en) begin
      if (qsize(d) < DEPTH) begin
        qpush(d, {sample, cnt[d] == len - 1});
        if (cnt[d] == len - 1) begin
          cnt[d] = 0;
          ph[d]  = 2;
        end else begin
          cnt[d]++;
        end
      end else begin
        ovf_m[d] = 1'b1;
      end
    end
    if (ph0 == 0 && st) begin
      ph[d] = 1; cnt[d] = 0; ovf_m[d] = 1'b0;
    end
    if (ph0 == 2 && popped_last) ph[d] = 0;
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  function automatic logic [VW-1:0] exp_vec(int d);
    logic        v;
    logic [DW:0] h;
    v = qsize(d) > 0;
    h = v ? qhead(d) : '0;
    return {v, ph[d] != 0, ovf_m[d], h[DW:1], h[0]
`ifdef STREAM_PRODUCER_PARITY_EN
            , ^h[DW:1]
`endif
           };
  endfunction

  function automatic logic [VW-1:0] obs_vec(int d);
    if (d == 0)
      return {va, busy_a, ovf_a, va ? da : 8'h00, va ? la : 1'b0
`ifdef STREAM_PRODUCER_PARITY_EN
              , va ? pa : 1'b0
`endif
             };
    return {vb, busy_b, ovf_b, vb ? db : 8'h00, vb ? lb : 1'b0
`ifdef STREAM_PRODUCER_PARITY_EN
            , vb ? pb : 1'b0
`endif
           };
  endfunction

  // Drive one cycle of inputs, record transfers, then compare both
  // producers with the model on the falling edge.
  task automatic step(input logic sa, input logic sb, input logic en,
                      input logic [DW-1:0] smp, input logic ra, input logic rb);
    start_a = sa; start_b = sb; sample_en = en; sample = smp;
    ready_a = ra; ready_b = rb;
    if (va === 1'b1 && ra) obs_a.push_back({da, la});
    if (vb === 1'b1 && rb) obs_b.push_back({db, lb});
    @(negedge clk);
    n_tests++;
    if (obs_vec(0) !== exp_vec(0)) begin
      n_fail++;
      $display("FAIL model_a @%0t: got %h, expected %h", $time, obs_vec(0), exp_vec(0));
    end
    n_tests++;
    if (obs_vec(1) !== exp_vec(1)) begin
      n_fail++;
      $display("FAIL model_b @%0t: got %h, expected %h", $time, obs_vec(1), exp_vec(1));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    step(0, 0, 0, 8'h00, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0);
    n_tests++;
    if ({va, da, la, busy_a, ovf_a} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_a: got %h, expected 000", {va, da, la, busy_a, ovf_a});
    end
    n_tests++;
    if ({vb, db, lb, busy_b, ovf_b} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_b: got %h, expected 000", {vb, db, lb, busy_b, ovf_b});
    end
`ifdef STREAM_PRODUCER_PARITY_EN
    n_tests++;
    if ({pa, pb} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_parity: got %b, expected 00", {pa, pb});
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    obs_a.delete();
    step(1, 0, 0, 8'h00, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      repeat (9) step(0, 0, 0, 8'h00, 1, 0);
      step(0, 0, 1, 8'(k), 1, 0);
      n_tests++;
      if ({va, da, la} !== {1'b1, 8'(k), k == 4}) begin
        n_fail++;
        $display("FAIL single_latency k=%0d: got %h, expected %h", k, {va, da, la}, {1'b1, 8'(k), k == 4});
      end
    end
    step(0, 0, 0, 8'h00, 1, 0);
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_end: got %b, expected 0", busy_a);
    end
    n_tests++;
    if (obs_a.size() != 4) begin
      n_fail++;
      $display("FAIL single_count: got %0d beats, expected 4", obs_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [DW:0] got, want;
      got  = (i < obs_a.size()) ? obs_a[i] : 9'hxxx;
      want = {8'(i + 1), i == 3};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL single_beat%0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_overflow_stall();
    int vals[8] = '{1, 2, 3, 4, 6, 7, 8, 9};
    obs_b.delete();
    step(0, 1, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 5; k++) step(0, 0, 1, 8'(k), 0, 0);
    n_tests++;
    if ({vb, db, ovf_b, busy_b} !== {1'b1, 8'd1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_set: got %h, expected %h", {vb, db, ovf_b, busy_b}, {1'b1, 8'd1, 1'b1, 1'b1});
    end
    repeat (3) begin
      step(0, 0, 0, 8'h00, 0, 0);
      n_tests++;
      if ({vb, db, lb} !== {1'b1, 8'd1, 1'b0}) begin
        n_fail++;
        $display("FAIL ovf_stall_stable: got %h, expected %h", {vb, db, lb}, {1'b1, 8'd1, 1'b0});
      end
    end
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if ({vb, db} !== {1'b1, 8'(k)}) begin
        n_fail++;
        $display("FAIL ovf_no_gap k=%0d: got %h, expected %h", k, {vb, db}, {1'b1, 8'(k)});
      end
      step(0, 0, 0, 8'h00, 0, 1);
    end
    for (int k = 6; k <= 9; k++) step(0, 0, 1, 8'(k), 0, 1);
    repeat (6) step(0, 0, 0, 8'h00, 0, 1);
    n_tests++;
    if ({busy_b, ovf_b} !== 2'b01 || obs_b.size() != 8) begin
      n_fail++;
      $display("FAIL ovf_end: got busy/ovf %b beats %0d, expected 01 and 8", {busy_b, ovf_b}, obs_b.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [DW:0] got, want;
      got  = (i < obs_b.size()) ? obs_b[i] : 9'hxxx;
      want = {8'(vals[i]), i == 7};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL ovf_beat%0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_full_with_pop();
    obs_b.delete();
    step(0, 1, 0, 8'h00, 0, 0);
    n_tests++;
    if (ovf_b !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_ovf_clear: got %b, expected 0", ovf_b);
    end
    for (int k = 10; k <= 13; k++) step(0, 0, 1, 8'(k), 0, 0);
    step(0, 0, 1, 8'd14, 0, 1);
    n_tests++;
    if ({ovf_b, vb, db} !== {1'b0, 1'b1, 8'd11}) begin
      n_fail++;
      $display("FAIL full_pop_accept: got %h, expected %h", {ovf_b, vb, db}, {1'b0, 1'b1, 8'd11});
    end
    for (int k = 15; k <= 17; k++) step(0, 0, 1, 8'(k), 0, 1);
    repeat (6) step(0, 0, 0, 8'h00, 0, 1);
    n_tests++;
    if (obs_b.size() != 8 || ovf_b !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_end: got %0d beats ovf %b, expected 8 beats ovf 0", obs_b.size(), ovf_b);
    end
    for (int i = 0; i < 8; i++) begin
      logic [DW:0] got, want;
      got  = (i < obs_b.size()) ? obs_b[i] : 9'hxxx;
      want = {8'(10 + i), i == 7};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL full_pop_beat%0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    obs_a.delete();
    step(1, 0, 0, 8'h00, 0, 0);
    step(0, 0, 1, 8'd1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    for (int k = 2; k <= 4; k++) step(0, 0, 1, 8'(k), 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    n_tests++;
    if ({busy_a, va, da, la} !== {1'b1, 1'b1, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL ignore_start: got %h, expected %h", {busy_a, va, da, la}, {1'b1, 1'b1, 8'd1, 1'b0});
    end
    repeat (6) step(0, 0, 0, 8'h00, 1, 0);
    n_tests++;
    if (obs_a.size() != 4 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_packet: got %0d beats busy %b, expected 4 beats busy 0", obs_a.size(), busy_a);
    end
    for (int i = 0; i < 4; i++) begin
      logic [DW:0] got, want;
      got  = (i < obs_a.size()) ? obs_a[i] : 9'hxxx;
      want = {8'(i + 1), i == 3};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL ignore_beat%0d: got %h, expected %h", i, got, want);
      end
    end
    repeat (3) begin
      step(0, 0, 1, 8'hAA, 1, 0);
      n_tests++;
      if ({va, busy_a, ovf_a} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_sample: got %b, expected 000", {va, busy_a, ovf_a});
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    step(0, 1, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 5; k++) step(0, 0, 1, 8'(k), 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    step(0, 0, 1, 8'd6, 0, 0);
    step(0, 0, 1, 8'd7, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 8'h00, 0, 0);
    rst = 1'b0;
    n_tests++;
    if ({va, busy_a, ovf_a, vb, busy_b, ovf_b} !== 6'b000000) begin
      n_fail++;
      $display("FAIL midreset: got %b, expected 000000", {va, busy_a, ovf_a, vb, busy_b, ovf_b});
    end
    obs_a.delete();
    step(1, 0, 0, 8'h00, 1, 0);
    for (int k = 21; k <= 24; k++) step(0, 0, 1, 8'(k), 1, 0);
    repeat (4) step(0, 0, 0, 8'h00, 1, 0);
    n_tests++;
    if (obs_a.size() != 4) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d beats, expected 4", obs_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [DW:0] got, want;
      got  = (i < obs_a.size()) ? obs_a[i] : 9'hxxx;
      want = {8'(21 + i), i == 3};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL midreset_beat%0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

`ifdef STREAM_PRODUCER_PARITY_EN
  task automatic test_parity();
    step(1, 0, 0, 8'h00, 0, 0);
    step(0, 0, 1, 8'h07, 0, 0);
    n_tests++;
    if ({va, da, pa} !== {1'b1, 8'h07, 1'b1}) begin
      n_fail++;
      $display("FAIL parity_07: got %h, expected %h", {va, da, pa}, {1'b1, 8'h07, 1'b1});
    end
    step(0, 0, 1, 8'h03, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0);
    n_tests++;
    if ({va, da, pa} !== {1'b1, 8'h03, 1'b0}) begin
      n_fail++;
      $display("FAIL parity_03: got %h, expected %h", {va, da, pa}, {1'b1, 8'h03, 1'b0});
    end
    step(0, 0, 1, 8'h05, 1, 0);
    step(0, 0, 1, 8'h06, 1, 0);
    repeat (4) step(0, 0, 0, 8'h00, 1, 0);
  endtask
`endif

  task automatic test_random();
    repeat (400) begin
      step($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_overflow_stall();
    test_full_with_pop();
    test_ignored_inputs();
    test_reset_mid_packet();
`ifdef STREAM_PRODUCER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
